// File: rtl/bt_event_packetizer.sv
// Debounces five push-buttons and emits a byte packet per accepted change into a FIFO.
// Optional macro BT_PKT_CHECKSUM_EN adds a trailing XOR checksum byte (4-byte packets instead of 3).
module bt_event_packetizer #(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter logic [7:0]  HEADER          = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] bt,
  input  logic       fifo_full,
  output logic [7:0] fifo_din,
  output logic       fifo_wr_en,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [20:0] DB_LAST = 21'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, HDR, SEQ, DAT, CHK} state_t;

`ifdef BT_PKT_CHECKSUM_EN
  localparam state_t LAST = CHK;

  function automatic logic [7:0] chk_byte(input logic [7:0] s, input logic [4:0] d);
    return HEADER ^ s ^ {3'b000, d};
  endfunction
`else
  localparam state_t LAST = DAT;
`endif

  logic [4:0]  bt_p0, bt_p1, bt_p2;
  logic [20:0] db_cnt;
  logic [4:0]  bt_db;
  logic        evt;
  state_t      state;
  logic [7:0]  seq;
  logic [4:0]  snap;
  logic        pend_vld;
  logic [4:0]  pend_data;
  logic        done;
  logic        evt_to_pend;
  logic        evt_drop;

  assign fifo_wr_en  = (state != IDLE) & ~fifo_full;
  assign done        = fifo_wr_en & (state == LAST);
  assign busy        = (state != IDLE) | pend_vld;
  // An event that coincides with the final byte starts the next packet directly.
  assign evt_to_pend = evt & (state != IDLE) & ~pend_vld & ~done;
  assign evt_drop    = evt & (state != IDLE) & pend_vld;

  always_comb begin
    fifo_din = 8'h00;
    case (state)
      HDR:     fifo_din = HEADER;
      SEQ:     fifo_din = seq;
      DAT:     fifo_din = {3'b000, snap};
`ifdef BT_PKT_CHECKSUM_EN
      CHK:     fifo_din = chk_byte(seq, snap);
`endif
      default: fifo_din = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bt_p0     <= '0;
      bt_p1     <= '0;
      bt_p2     <= '0;
      db_cnt    <= '0;
      bt_db     <= '0;
      evt       <= 1'b0;
      state     <= IDLE;
      seq       <= '0;
      snap      <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      drop_cnt  <= '0;
    end else begin
      // synchronizer (p0, p1) and previous-sample register (p2)
      bt_p0 <= bt;
      bt_p1 <= bt_p0;
      bt_p2 <= bt_p1;

      // debounce: accept the vector after DEBOUNCE_CYCLES stable samples
      evt <= 1'b0;
      if (bt_p1 != bt_p2) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_LAST) begin
        db_cnt <= db_cnt + 21'd1;
      end else if (bt_p1 != bt_db) begin
        bt_db <= bt_p1;
        evt   <= 1'b1;
      end

      if (evt_to_pend) begin
        pend_vld  <= 1'b1;
        pend_data <= bt_db;
      end
      if (evt_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      // packet sequencer: each emitting state advances only when its byte is written
      case (state)
        IDLE: if (evt) begin
          state <= HDR;
          snap  <= bt_db;
        end
        HDR: if (fifo_wr_en) state <= SEQ;
        SEQ: if (fifo_wr_en) state <= DAT;
`ifdef BT_PKT_CHECKSUM_EN
        DAT: if (fifo_wr_en) state <= CHK;
`endif
        default: ;
      endcase

      if (done) begin
        seq <= seq + 8'd1;
        if (pend_vld) begin
          state    <= HDR;
          snap     <= pend_data;
          pend_vld <= 1'b0;
        end else if (evt) begin
          state <= HDR;
          snap  <= bt_db;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bt_event_packetizer.sv
// Directed bench for bt_event_packetizer with DEBOUNCE_CYCLES=4; adapts to BT_PKT_CHECKSUM_EN.
module tb_bt_event_packetizer;

`ifdef BT_PKT_CHECKSUM_EN
  localparam int PLEN = 4;
`else
  localparam int PLEN = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] bt;
  logic       fifo_full;
  logic [7:0] fifo_din;
  logic       fifo_wr_en;
  logic       busy;
  logic [7:0] drop_cnt;

  bt_event_packetizer #(.DEBOUNCE_CYCLES(4), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .bt(bt), .fifo_full(fifo_full),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] wq[$];
  int         wc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wq.push_back(fifo_din);
      wc.push_back(cyc);
    end
  end

  typedef struct {
    logic [4:0] bt;
    logic [7:0] seq;
    logic [7:0] dat;
    logic [7:0] chk;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    wq.delete();
    wc.delete();
  endtask

  task automatic do_reset(input logic [4:0] b);
    rst = 1'b1;
    bt = b;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 clear_q();
  endtask

  task automatic wait_bytes(input int n, input string name);
    int k = 0;
    while (wq.size() < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (wq.size() < n) check({name, "_timeout"}, wq.size(), n);
  endtask

  function automatic logic [7:0] qbyte(input int idx);
    if (idx < wq.size()) return wq[idx];
    return 8'hxx;
  endfunction

  task automatic check_pkt(input string name, input int base,
                           input logic [7:0] s, input logic [7:0] d, input logic [7:0] c);
    logic [7:0] exp;
    for (int k = 0; k < PLEN; k++) begin
      exp = (k == 0) ? 8'hA5 : (k == 1) ? s : (k == 2) ? d : c;
      check($sformatf("%s_b%0d", name, k), qbyte(base + k), exp);
    end
  endtask

  function automatic int span(input int a, input int b);
    if (b < wc.size()) return wc[b] - wc[a];
    return -1;
  endfunction

  initial begin
    int bad;
    vt[0] = '{5'b00001, 8'h00, 8'h01, 8'hA4};
    vt[1] = '{5'b10000, 8'h01, 8'h10, 8'hB4};
    vt[2] = '{5'b11111, 8'h02, 8'h1F, 8'hB8};
    vt[3] = '{5'b01010, 8'h03, 8'h0A, 8'hAC};
    vt[4] = '{5'b00000, 8'h04, 8'h00, 8'hA1};

    rst = 1'b1;
    bt = 5'b0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_din", fifo_din, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_cnt, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 clear_q();

    for (int i = 0; i < 5; i++) begin
      bt = vt[i].bt;
      wait_bytes(PLEN, $sformatf("row%0d", i));
      repeat (4) @(posedge clk);
      check($sformatf("row%0d_len", i), wq.size(), PLEN);
      check_pkt($sformatf("row%0d", i), 0, vt[i].seq, vt[i].dat, vt[i].chk);
      check($sformatf("row%0d_consec", i), span(0, PLEN - 1), PLEN - 1);
      @(negedge clk);
      check($sformatf("row%0d_busy", i), busy, 1'b0);
      check($sformatf("row%0d_drop", i), drop_cnt, 8'h00);
      clear_q();
    end

    // short glitch must not produce an event
    bt = 5'b00010;
    repeat (3) @(posedge clk);
    #1 bt = 5'b00000;
    repeat (20) @(posedge clk);
    check("glitch_writes", wq.size(), 0);
    check("glitch_busy", busy, 1'b0);

    // stall on the SEQ byte for 5 cycles
    do_reset(5'b0);
    bt = 5'b00001;
    wait_bytes(1, "stall_hdr");
    #1 fifo_full = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("stall_din%0d", j), fifo_din, 8'h00);
      check($sformatf("stall_wr%0d", j), fifo_wr_en, 1'b0);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_bytes(PLEN, "stall");
    repeat (4) @(posedge clk);
    check("stall_len", wq.size(), PLEN);
    check_pkt("stall", 0, 8'h00, 8'h01, 8'hA4);

    // two further changes while stalled: one pends, one drops
    do_reset(5'b0);
    bt = 5'b00001;
    wait_bytes(1, "pend_hdr");
    #1 fifo_full = 1'b1;
    bt = 5'b00011;
    repeat (12) @(posedge clk);
    #1 bt = 5'b00111;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("pend_busy", busy, 1'b1);
    check("pend_drop_mid", drop_cnt, 8'h01);
    check("pend_hold_din", fifo_din, 8'h00);
    @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_bytes(2 * PLEN, "pend");
    repeat (4) @(posedge clk);
    check("pend_len", wq.size(), 2 * PLEN);
    check_pkt("pend_p0", 0, 8'h00, 8'h01, 8'hA4);
    check_pkt("pend_p1", PLEN, 8'h01, 8'h03, 8'hA7);
    check("pend_b2b", span(PLEN - 1, PLEN), 1);
    check("pend_consec", span(PLEN, 2 * PLEN - 1), PLEN - 1);
    @(negedge clk);
    check("pend_drop_end", drop_cnt, 8'h01);
    check("pend_busy_end", busy, 1'b0);

    // reset during the DAT byte abandons the packet
    do_reset(5'b0);
    bt = 5'b00001;
    wait_bytes(1, "rstmid_hdr");
    @(posedge clk);
    #1 rst = 1'b1;
    bt = 5'b00000;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    check("rstmid_len", wq.size(), 3);
    check("rstmid_b0", qbyte(0), 8'hA5);
    check("rstmid_b1", qbyte(1), 8'h00);
    check("rstmid_b2", qbyte(2), 8'h01);
    clear_q();
    bt = 5'b00100;
    wait_bytes(PLEN, "rstmid_next");
    repeat (4) @(posedge clk);
    check("rstmid_next_len", wq.size(), PLEN);
    check_pkt("rstmid_next", 0, 8'h00, 8'h04, 8'hA1);

    // 256 packets then sequence wraps to 00
    do_reset(5'b0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      #1 bt = (i % 2 == 1) ? 5'b01000 : 5'b10000;
      wait_bytes(PLEN, "wrap");
      if (i == 0) check_pkt("wrap_first", 0, 8'h00, 8'h10, 8'hB5);
      if (qbyte(1) !== 8'(i)) bad++;
      clear_q();
    end
    check("wrap_seq_all", bad, 0);
    #1 bt = 5'b00011;
    wait_bytes(PLEN, "wrap_after");
    repeat (4) @(posedge clk);
    check_pkt("wrap_after", 0, 8'h00, 8'h03, 8'hA6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
